matrix_seq_ctrl: RTL and testbench



---
 rtl/matrix_pkg.sv | 31 +++
 rtl/matrix_mac.sv | 31 +++
 rtl/matrix_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_matrix_seq_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and index helper for the sequential 3x3 matrix multiplier.
// Optional cycle counter is enabled in the top level by defining MATSEQ_CYCLE_CNT_EN.
package matrix_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned ACC_W      = 19;
    localparam int unsigned N          = 3;
    localparam int unsigned NUM_ELEM   = N * N;

    localparam int unsigned LOAD_IDX_W = 5;
    localparam int unsigned IJK_W      = 2;
    localparam int unsigned OUT_IDX_W  = 4;

    localparam logic [LOAD_IDX_W-1:0] LOAD_LAST = 5'd17;
    localparam logic [LOAD_IDX_W-1:0] LOAD_B0   = 5'd9;
    localparam logic [IJK_W-1:0]      IJK_LAST  = 2'd2;
    localparam logic [OUT_IDX_W-1:0]  OUT_LAST  = 4'd8;

    typedef enum logic [1:0] {
        StLoad    = 2'd0,
        StCompute = 2'd1,
        StOutput  = 2'd2
    } state_e;

    // Row-major flat index r*N + c.
    function automatic logic [OUT_IDX_W-1:0] elem_idx(input logic [IJK_W-1:0] r,
                                                      input logic [IJK_W-1:0] c);
        return OUT_IDX_W'(r) * OUT_IDX_W'(N) + OUT_IDX_W'(c);
    endfunction

endpackage

// File: rtl/matrix_mac.sv
// Single 8x8 multiply-accumulate unit shared across all 27 products.
// acc_next is combinational so the controller can store a finished dot product directly.
module matrix_mac
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc_next
);

    logic [ACC_W-1:0]    acc_q;
    logic [2*DATA_W-1:0] prod;

    always_comb begin
        prod     = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        acc_next = (clr ? '0 : acc_q) + ACC_W'(prod);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_next;
        end
    end

endmodule

// File: rtl/matrix_seq_ctrl.sv
// Sequential 3x3 matrix multiply controller: load A,B, 27-cycle shared-MAC compute, stream C.
// Define MATSEQ_CYCLE_CNT_EN to add the 16-bit cycle_cnt output.
module matrix_seq_ctrl
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy
`ifdef MATSEQ_CYCLE_CNT_EN
    ,
    output logic [15:0]       cycle_cnt
`endif
);

    state_e                state_q;
    logic [LOAD_IDX_W-1:0] load_idx_q;
    logic [IJK_W-1:0]      i_q;
    logic [IJK_W-1:0]      j_q;
    logic [IJK_W-1:0]      k_q;
    logic [OUT_IDX_W-1:0]  out_idx_q;

    logic [DATA_W-1:0]     a_buf_q [NUM_ELEM];
    logic [DATA_W-1:0]     b_buf_q [NUM_ELEM];
    logic [ACC_W-1:0]      c_buf_q [NUM_ELEM];

    logic                  in_hs;
    logic                  out_hs;
    logic [DATA_W-1:0]     mac_a;
    logic [DATA_W-1:0]     mac_b;
    logic [ACC_W-1:0]      mac_acc_next;
    logic                  mac_en;
    logic                  mac_clr;

    always_comb begin
        in_hs   = in_valid & in_ready;
        out_hs  = out_valid & out_ready;
        mac_a   = a_buf_q[elem_idx(i_q, k_q)];
        mac_b   = b_buf_q[elem_idx(k_q, j_q)];
        mac_en  = (state_q == StCompute);
        mac_clr = (k_q == '0);
    end

    matrix_mac u_mac (
        .clk      (clk),
        .rst      (rst),
        .en       (mac_en),
        .clr      (mac_clr),
        .a        (mac_a),
        .b        (mac_b),
        .acc_next (mac_acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StLoad;
            load_idx_q <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            out_idx_q  <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            for (int unsigned n = 0; n < NUM_ELEM; n++) begin
                a_buf_q[n] <= '0;
                b_buf_q[n] <= '0;
                c_buf_q[n] <= '0;
            end
        end else begin
            case (state_q)
                StLoad: begin
                    in_ready <= 1'b1;
                    // Storage only on a handshake, so X on in_data while idle never lands.
                    if (in_hs) begin
                        if (load_idx_q < LOAD_B0) begin
                            a_buf_q[load_idx_q[OUT_IDX_W-1:0]] <= in_data;
                        end else begin
                            b_buf_q[OUT_IDX_W'(load_idx_q - LOAD_B0)] <= in_data;
                        end
                        if (load_idx_q == LOAD_LAST) begin
                            load_idx_q <= '0;
                            in_ready   <= 1'b0;
                            busy       <= 1'b1;
                            i_q        <= '0;
                            j_q        <= '0;
                            k_q        <= '0;
                            state_q    <= StCompute;
                        end else begin
                            load_idx_q <= load_idx_q + 5'd1;
                        end
                    end
                end

                StCompute: begin
                    if (k_q == IJK_LAST) begin
                        c_buf_q[elem_idx(i_q, j_q)] <= mac_acc_next;
                        k_q <= '0;
                        if (j_q == IJK_LAST) begin
                            j_q <= '0;
                            if (i_q == IJK_LAST) begin
                                i_q       <= '0;
                                out_idx_q <= '0;
                                out_valid <= 1'b1;
                                out_data  <= c_buf_q[0];
                                out_last  <= 1'b0;
                                state_q   <= StOutput;
                            end else begin
                                i_q <= i_q + 2'd1;
                            end
                        end else begin
                            j_q <= j_q + 2'd1;
                        end
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end

                StOutput: begin
                    if (out_hs) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            out_idx_q <= '0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            state_q   <= StLoad;
                        end else begin
                            out_idx_q <= out_idx_q + 4'd1;
                            out_data  <= c_buf_q[out_idx_q + 4'd1];
                            out_last  <= ((out_idx_q + 4'd1) == OUT_LAST);
                        end
                    end
                end

                default: begin
                    state_q <= StLoad;
                end
            endcase
        end
    end

`ifdef MATSEQ_CYCLE_CNT_EN
    logic cnt_run_q;

    // The cycle that accepts the first A beat is itself counted, so a stall-free matrix reads 54.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            cnt_run_q <= 1'b0;
        end else if (state_q == StLoad && in_hs && load_idx_q == '0) begin
            cycle_cnt <= 16'd1;
            cnt_run_q <= 1'b1;
        end else if (cnt_run_q) begin
            if (cycle_cnt != 16'hFFFF) begin
                cycle_cnt <= cycle_cnt + 16'd1;
            end
            if (out_hs && out_last) begin
                cnt_run_q <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// Directed bench for matrix_seq_ctrl with hand-computed result tables.
// Define MATSEQ_CYCLE_CNT_EN to also exercise cycle_cnt.
module tb_matrix_seq_ctrl;

    typedef logic [7:0]  mat_t [18];
    typedef logic [18:0] res_t [9];

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [18:0] out_data;
    logic        out_last;
    logic        busy;
`ifdef MATSEQ_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int busy_ready_cnt = 0;

    mat_t m_std = '{8'hFF, 8'h10, 8'hB5, 8'hA1, 8'hA1, 8'h11, 8'h0C, 8'h00, 8'h12,
                    8'h11, 8'h1D, 8'hD1, 8'hFF, 8'hEE, 8'h61, 8'h21, 8'h18, 8'h13};
    res_t e_std = '{19'h03834, 19'h03CBB, 19'h0E3AE, 19'h0AD41, 19'h0A983,
                    19'h0C1B5, 19'h0031E, 19'h0030C, 19'h00B22};
    mat_t m_id  = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1,
                    8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    res_t e_id  = '{19'd1, 19'd2, 19'd3, 19'd4, 19'd5, 19'd6, 19'd7, 19'd8, 19'd9};
    mat_t m_ff  = '{default: 8'hFF};
    res_t e_ff  = '{default: 19'h2FA03};

    matrix_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
`ifdef MATSEQ_CYCLE_CNT_EN
        ,
        .cycle_cnt (cycle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy === 1'b1 && in_ready === 1'b1) busy_ready_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Drives beats start..17, returns one cycle after the final handshake edge.
    task automatic send_beats(input mat_t v, input int start, input bit gaps, output bit ok);
        int n;
        int guard;
        n = start;
        guard = 0;
        while (n < 18 && guard < 500) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 'x;
            end else begin
                in_valid = 1'b1;
                in_data  = v[n];
                if (in_ready === 1'b1) n++;
            end
        end
        ok = (n == 18);
        @(posedge clk);
        #1;
    endtask

    // Counts falling edges after the final-B handshake until out_valid; -1 on timeout.
    task automatic wait_valid(output int lat);
        out_ready = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1) break;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    // Starts at the falling edge where out_valid is first seen; stops at the out_last handshake.
    task automatic collect(input bit bp, output res_t got, output logic [8:0] lasts,
                           output int nbeats, output int unstable);
        logic [19:0] prev;
        bit          prev_stall;
        bit          done;
        int          guard;
        got        = '{default: '0};
        lasts      = '0;
        nbeats     = 0;
        unstable   = 0;
        prev_stall = 1'b0;
        prev       = '0;
        done       = 1'b0;
        guard      = 0;
        while (!done && guard < 400) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall && out_valid === 1'b1 && {out_last, out_data} !== prev) unstable++;
            if (out_valid === 1'b1 && out_ready) begin
                if (nbeats < 9) begin
                    got[nbeats]   = out_data;
                    lasts[nbeats] = out_last;
                end
                nbeats++;
                if (out_last === 1'b1 || nbeats >= 12) done = 1'b1;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev       = {out_last, out_data};
            if (!done) begin
                @(negedge clk);
                guard++;
            end
        end
    endtask

    // Full transaction; post = {out_valid, in_ready, busy} the cycle after the last output.
    task automatic run_matrix(input mat_t m, input bit gaps, input bit bp, output int lat,
                              output res_t got, output logic [8:0] lasts, output int nbeats,
                              output int unstable, output logic [2:0] post);
        bit ok;
        send_beats(m, 0, gaps, ok);
        in_valid = 1'b0;
        in_data  = 'x;
        wait_valid(lat);
        if (!ok) lat = -2;
        collect(bp, got, lasts, nbeats, unstable);
        @(negedge clk);
        post = {out_valid, in_ready, busy};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 19'd0 ||
            out_last !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b valid=%b data=%h last=%b busy=%b, want all 0",
                     in_ready, out_valid, out_data, out_last, busy);
        end
`ifdef MATSEQ_CYCLE_CNT_EN
        checks++;
        if (cycle_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_cycle_cnt: got %0d want 0", cycle_cnt);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_ready: ready=%b busy=%b want ready=1 busy=0", in_ready, busy);
        end
    endtask

    task automatic test_standard();
        int lat, nb, unst;
        res_t got;
        logic [8:0] lasts;
        logic [2:0] post;
        run_matrix(m_std, 1'b0, 1'b0, lat, got, lasts, nb, unst, post);
        checks++;
        if (lat != 28) begin
            failures++;
            $display("FAIL std_latency: got %0d want 28", lat);
        end
        checks++;
        if (nb != 9) begin
            failures++;
            $display("FAIL std_beats: got %0d want 9", nb);
        end
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (got[n] !== e_std[n] || lasts[n] !== (n == 8)) begin
                failures++;
                $display("FAIL std_c%0d: got %h last=%b want %h last=%b",
                         n + 1, got[n], lasts[n], e_std[n], (n == 8));
            end
        end
        checks++;
        if (post !== 3'b010) begin
            failures++;
            $display("FAIL std_return_load: {valid,ready,busy}=%b want 010", post);
        end
    endtask

    task automatic test_identity_and_max();
        int lat, nb, unst;
        res_t got;
        logic [8:0] lasts;
        logic [2:0] post;
        run_matrix(m_id, 1'b0, 1'b0, lat, got, lasts, nb, unst, post);
        checks++;
        if (nb != 9 || got !== e_id || lasts !== 9'h100) begin
            failures++;
            $display("FAIL identity: beats=%0d c1=%h c9=%h lasts=%b want 9 beats 1..9 lasts=100000000",
                     nb, got[0], got[8], lasts);
        end
        run_matrix(m_ff, 1'b0, 1'b0, lat, got, lasts, nb, unst, post);
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (got[n] !== e_ff[n]) begin
                failures++;
                $display("FAIL allff_c%0d: got %h want 2fa03", n + 1, got[n]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat, nb, unst;
        res_t got;
        logic [8:0] lasts;
        logic [2:0] post;
        for (int r = 0; r < 2; r++) begin
            run_matrix(r == 0 ? m_std : m_id, 1'b1, 1'b1, lat, got, lasts, nb, unst, post);
            checks++;
            if (lat != 28) begin
                failures++;
                $display("FAIL bp_latency_%0d: got %0d want 28", r, lat);
            end
            checks++;
            if (nb != 9 || unst != 0 || lasts !== 9'h100) begin
                failures++;
                $display("FAIL bp_stream_%0d: beats=%0d unstable=%0d lasts=%b want 9/0/100000000",
                         r, nb, unst, lasts);
            end
            checks++;
            if (got !== (r == 0 ? e_std : e_id)) begin
                failures++;
                $display("FAIL bp_data_%0d: got c1=%h c5=%h c9=%h want table values",
                         r, got[0], got[4], got[8]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, nb, unst, snap;
        bit ok;
        res_t got;
        logic [8:0] lasts;
        logic [2:0] post;
        snap = busy_ready_cnt;
        send_beats(m_std, 0, 1'b0, ok);
        in_valid = 1'b1;
        in_data  = m_ff[0];
        wait_valid(lat);
        collect(1'b0, got, lasts, nb, unst);
        @(negedge clk);
        checks++;
        if (!ok || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_reopen: ok=%b ready=%b valid=%b want 1/1/0", ok, in_ready, out_valid);
        end
        checks++;
        if (got !== e_std || nb != 9) begin
            failures++;
            $display("FAIL b2b_first: beats=%0d c1=%h c9=%h want 9 03834 00b22", nb, got[0], got[8]);
        end
        send_beats(m_ff, 1, 1'b0, ok);
        in_valid = 1'b0;
        wait_valid(lat);
        collect(1'b0, got, lasts, nb, unst);
        checks++;
        if (!ok || got !== e_ff || nb != 9 || lat != 28) begin
            failures++;
            $display("FAIL b2b_second: ok=%b lat=%0d beats=%0d c1=%h want 1 28 9 2fa03",
                     ok, lat, nb, got[0]);
        end
        @(negedge clk);
        checks++;
        if (busy_ready_cnt != snap) begin
            failures++;
            $display("FAIL b2b_ready_while_busy: got %0d cycles want 0", busy_ready_cnt - snap);
        end
    endtask

    task automatic test_reset_mid();
        int lat, nb, unst;
        bit ok;
        res_t got;
        logic [8:0] lasts;
        logic [2:0] post;
        // Abort during COMPUTE
        send_beats(m_std, 0, 1'b0, ok);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_compute_during: busy=%b valid=%b ready=%b want 000",
                     busy, out_valid, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_compute_after: busy=%b valid=%b ready=%b want 0 0 1",
                     busy, out_valid, in_ready);
        end
        run_matrix(m_id, 1'b0, 1'b0, lat, got, lasts, nb, unst, post);
        checks++;
        if (got !== e_id || nb != 9 || lat != 28) begin
            failures++;
            $display("FAIL rst_compute_next: lat=%0d beats=%0d c1=%h c9=%h want 28 9 1 9",
                     lat, nb, got[0], got[8]);
        end
        // Abort during OUTPUT after c4
        send_beats(m_std, 0, 1'b0, ok);
        in_valid = 1'b0;
        wait_valid(lat);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 19'h0A983) begin
            failures++;
            $display("FAIL out_c5_before_rst: valid=%b data=%h want 1 0a983", out_valid, out_data);
        end
        out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_output_after: busy=%b valid=%b ready=%b want 0 0 1",
                     busy, out_valid, in_ready);
        end
        run_matrix(m_id, 1'b0, 1'b0, lat, got, lasts, nb, unst, post);
        checks++;
        if (got !== e_id || nb != 9 || lasts !== 9'h100) begin
            failures++;
            $display("FAIL rst_output_next: beats=%0d c1=%h c9=%h lasts=%b want 9 1 9 100000000",
                     nb, got[0], got[8], lasts);
        end
    endtask

`ifdef MATSEQ_CYCLE_CNT_EN
    task automatic test_cycle_cnt();
        int lat, nb, unst;
        res_t got;
        logic [8:0] lasts;
        logic [2:0] post;
        run_matrix(m_std, 1'b0, 1'b0, lat, got, lasts, nb, unst, post);
        checks++;
        if (cycle_cnt !== 16'd54) begin
            failures++;
            $display("FAIL cycle_cnt_final: got %0d want 54", cycle_cnt);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (cycle_cnt !== 16'd54) begin
            failures++;
            $display("FAIL cycle_cnt_hold: got %0d want 54", cycle_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        test_reset();
        test_standard();
        test_identity_and_max();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef MATSEQ_CYCLE_CNT_EN
        test_cycle_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
